nibble_serial_subtractor: RTL
=============================

NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; SHALL be a nonzero multiple of 4.
REQ-002 Derived constant N = WIDTH/4: number of nibble steps.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-005 start  input  1  request a subtraction; sampled on rising edge of clk.
REQ-006 a  input  WIDTH  minuend; sampled only with an accepted start.
REQ-007 b  input  WIDTH  subtrahend; sampled only with an accepted start.
REQ-008 busy  output  1  high while a subtraction is in progress.
REQ-009 done  output  1  single-cycle completion pulse.
REQ-010 diff  output  WIDTH  result a - b, modulo 2^WIDTH.
REQ-011 borrow  output  1  high when a < b (unsigned).
REQ-012 overflow  output  1  signed two's-complement overflow of a - b.
REQ-013 zero  output  1  high when diff == 0.
REQ-014 negative  output  1  equal to diff[WIDTH-1].

Function
REQ-015 The block SHALL have three states:
- IDLE
- RUN
- DONE
REQ-016 Start acceptance:
- A start is accepted in IDLE or DONE only.
- On acceptance, a and b SHALL be latched internally, the step counter cleared, the carry register set to 1, and the state SHALL move to RUN.
REQ-017 start SHALL be ignored while in RUN; latched operands are unaffected.
REQ-018 Each RUN cycle SHALL process exactly one nibble, least significant first:
- Compute a_nib + ~b_nib + carry with a single 4-bit add stage.
- Store the 4-bit result into the nibble position of diff.
- Store the stage carry-out in the carry register.
REQ-019 After nibble N-1 is processed, the state SHALL move to DONE.
REQ-020 Flag registration, on that same edge:
- borrow = NOT final carry.
- overflow = (a[MSB] != b[MSB]) AND (diff[MSB] != a[MSB]).
- zero and negative registered from the complete diff.
REQ-021 Latency: with start accepted at edge t0, done SHALL be high for exactly the one cycle following edge t0+N (8 cycles for WIDTH=32).
REQ-022 busy SHALL be high from edge t0 until edge t0+N, and low in IDLE and DONE.
REQ-023 From DONE:
- The state SHALL return to IDLE on the next edge, unless start is high.
- If start is high, a new operation SHALL be accepted (back-to-back) and done SHALL drop.
REQ-024 diff, borrow, overflow, zero and negative SHALL be updated only when an operation completes. They SHALL hold their values otherwise, including throughout a following RUN.
REQ-025 Intermediate nibbles of diff SHALL NOT be visible on the diff output before completion. Partial results SHALL be kept in an internal register.
REQ-026 a == b SHALL give: diff = 0, zero = 1, borrow = 0, overflow = 0.
REQ-027 Changes on a and b while busy SHALL have no effect on the result.

Reset
REQ-028 When rst_n is low, the state SHALL be IDLE and the following SHALL all be 0:
- busy, done, diff, borrow, overflow, zero, negative
- the step counter and the internal operand and partial-result registers
REQ-029 Reset asserted mid-operation SHALL abort the operation with no done pulse. The first start after rst_n rises SHALL be processed normally.

Verification (WIDTH=32)
REQ-030 a=5, b=3, start pulsed -> 8 cycles later done=1 for one cycle, busy=0, diff=0x00000002, borrow=0, overflow=0, zero=0, negative=0.
REQ-031 a=3, b=5 -> diff=0xFFFFFFFE, borrow=1, negative=1, overflow=0, zero=0.
REQ-032 a=0x80000000, b=1 -> diff=0x7FFFFFFF, overflow=1, borrow=0, negative=0; and a=0x1234ABCD, b=0x1234ABCD -> diff=0, zero=1.
REQ-033 start held high with new operands during RUN -> ignored, first result delivered unchanged; start high in the done cycle with a=10, b=4 -> second done 8 cycles later with diff=6.
REQ-034 rst_n pulsed low at step 4 of a run -> all outputs 0 immediately, no done pulse; a subsequent start with a=7, b=7 completes with zero=1 after 8 cycles.

Source files
------------

// File: rtl/nibble_serial_subtractor_if.sv
// Operand/result bundle for the nibble-serial subtractor.
// The master issues start with operands; the slave returns status and results.
interface nibble_serial_subtractor_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, overflow, zero, negative
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, overflow, zero, negative
    );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Computes a - b one nibble per cycle through a single 4-bit add stage.
// Results and flags are published only when the last nibble completes.
module nibble_serial_subtractor #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    nibble_serial_subtractor_if.slave   bus
);
    localparam int unsigned N  = WIDTH / 4;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IW = (WIDTH > 4) ? $clog2(WIDTH) : 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] part_q;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic [IW-1:0]    idx;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       sum;
    logic [WIDTH-1:0] part_next;
    logic             last;

    // Single add stage: a_nib + ~b_nib + carry, merged into the partial result.
    always_comb begin
        idx       = IW'({cnt, 2'b00});
        a_nib     = a_q[idx +: 4];
        b_nib     = b_q[idx +: 4];
        sum       = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0000, carry};
        part_next = part_q;
        part_next[idx +: 4] = sum[3:0];
        last      = (cnt == CW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            part_q       <= '0;
            cnt          <= '0;
            carry        <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.diff     <= '0;
            bus.borrow   <= 1'b0;
            bus.overflow <= 1'b0;
            bus.zero     <= 1'b0;
            bus.negative <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        part_q   <= '0;
                        cnt      <= '0;
                        carry    <= 1'b1;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    part_q <= part_next;
                    carry  <= sum[4];
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        // Final nibble: publish result and flags together.
                        state        <= DONE;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        bus.diff     <= part_next;
                        bus.borrow   <= ~sum[4];
                        bus.overflow <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) &
                                        (part_next[WIDTH-1] ^ a_q[WIDTH-1]);
                        bus.zero     <= (part_next == '0);
                        bus.negative <= part_next[WIDTH-1];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
